sdram_fifo_ctrl: RTL and testbench

User-side buffering and request layer of the SDRAM subsystem. It accepts 16-bit write data from a 50 MHz user domain into a dual-clock write FIFO, and issues burst write requests with linearly advancing addresses to the 100 MHz SDRAM controller. In the other direction it issues burst read requests and buffers the returned data in a dual-clock read FIFO that the user drains at 50 MHz. It sits between user logic and the SDRAM command controller (init/refresh/write/read arbiter).

---
 rtl/sdram_fifo_ctrl_pkg.sv | 15 +
 rtl/sdram_fifo_ctrl_async_fifo.sv | 81 ++++++++
 rtl/sdram_fifo_ctrl.sv | 125 ++++++++++++
 tb/tb_sdram_fifo_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_fifo_ctrl_pkg.sv
// Shared constants and types for the SDRAM user-side FIFO/request layer.
package sdram_fifo_ctrl_pkg;

  localparam int DATA_W       = 16;
  localparam int ADDR_W       = 24;
  localparam int FIFO_DEPTH_D = 1024;
  localparam int CNT_W        = 10;

  typedef enum logic [1:0] {
    REQ_IDLE = 2'd0,
    REQ_WR   = 2'd1,
    REQ_RD   = 2'd2
  } req_e;

endpackage

// File: rtl/sdram_fifo_ctrl_async_fifo.sv
// Dual-clock FIFO: Gray-coded pointers, two-flop synchronisers, async clear,
// registered (non-show-ahead) read data that holds its value when empty.
module async_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 1024
) (
  input  logic                       i_aclr_n,
  input  logic                       i_wclk,
  input  logic                       i_wrreq,
  input  logic [DW-1:0]              i_wdata,
  output logic [$clog2(DEPTH)-1:0]   o_wusedw,
  input  logic                       i_rclk,
  input  logic                       i_rdreq,
  output logic [DW-1:0]              o_q,
  output logic [$clog2(DEPTH)-1:0]   o_rusedw
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW:0]   r_wbin, r_wgray, r_rbin, r_rgray;
  logic [PW:0]   r_rgray_s1, r_rgray_s2, r_wgray_s1, r_wgray_s2;
  logic [PW:0]   w_wbin_nxt, w_rbin_nxt, w_rbin_sync, w_wbin_sync;
  logic [PW:0]   w_wdiff, w_rdiff;
  logic          w_full, w_empty;

  function automatic logic [PW:0] gray2bin(input logic [PW:0] g);
    logic [PW:0] b;
    b[PW] = g[PW];
    for (int i = PW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Full when the write pointer has lapped the synchronised read pointer.
  assign w_full     = (r_wgray == {~r_rgray_s2[PW:PW-1], r_rgray_s2[PW-2:0]});
  assign w_empty    = (r_rgray == r_wgray_s2);
  assign w_wbin_nxt = r_wbin + {{PW{1'b0}}, (i_wrreq && !w_full)};
  assign w_rbin_nxt = r_rbin + {{PW{1'b0}}, (i_rdreq && !w_empty)};

  always_ff @(posedge i_wclk) begin
    if (i_wrreq && !w_full) r_mem[r_wbin[PW-1:0]] <= i_wdata;
  end

  always_ff @(posedge i_wclk or negedge i_aclr_n) begin
    if (!i_aclr_n) begin
      r_wbin     <= '0;
      r_wgray    <= '0;
      r_rgray_s1 <= '0;
      r_rgray_s2 <= '0;
    end else begin
      r_wbin     <= w_wbin_nxt;
      r_wgray    <= w_wbin_nxt ^ (w_wbin_nxt >> 1);
      r_rgray_s1 <= r_rgray;
      r_rgray_s2 <= r_rgray_s1;
    end
  end

  always_ff @(posedge i_rclk or negedge i_aclr_n) begin
    if (!i_aclr_n) begin
      r_rbin     <= '0;
      r_rgray    <= '0;
      r_wgray_s1 <= '0;
      r_wgray_s2 <= '0;
      o_q        <= '0;
    end else begin
      r_rbin     <= w_rbin_nxt;
      r_rgray    <= w_rbin_nxt ^ (w_rbin_nxt >> 1);
      r_wgray_s1 <= r_wgray;
      r_wgray_s2 <= r_wgray_s1;
      if (i_rdreq && !w_empty) o_q <= r_mem[r_rbin[PW-1:0]];
    end
  end

  assign w_rbin_sync = gray2bin(r_rgray_s2);
  assign w_wbin_sync = gray2bin(r_wgray_s2);
  assign w_wdiff     = r_wbin - w_rbin_sync;
  assign w_rdiff     = w_wbin_sync - r_rbin;
  assign o_wusedw    = w_wdiff[PW-1:0];
  assign o_rusedw    = w_rdiff[PW-1:0];

endmodule

// File: rtl/sdram_fifo_ctrl.sv
// User-side write/read FIFOs plus burst request and linear address generation
// toward the SDRAM command controller.
module sdram_fifo_ctrl
  import sdram_fifo_ctrl_pkg::*;
#(
  parameter int DW         = DATA_W,
  parameter int AW         = ADDR_W,
  parameter int FIFO_DEPTH = FIFO_DEPTH_D
) (
  input  logic             clk_50m,
  input  logic             clk_100m,
  input  logic             rst_n,
  input  logic             wr_fifo_wr_req,
  input  logic [DW-1:0]    wr_fifo_wr_data,
  input  logic [AW-1:0]    sdram_wr_b_addr,
  input  logic [AW-1:0]    sdram_wr_e_addr,
  input  logic [CNT_W-1:0] wr_burst_len,
  input  logic             wr_rst,
  input  logic             rd_fifo_rd_req,
  input  logic [AW-1:0]    sdram_rd_b_addr,
  input  logic [AW-1:0]    sdram_rd_e_addr,
  input  logic [CNT_W-1:0] rd_burst_len,
  input  logic             rd_rst,
  input  logic             read_valid,
  output logic [DW-1:0]    rd_fifo_rd_data,
  output logic [CNT_W-1:0] rd_fifo_num,
  input  logic             init_end,
  output logic             sdram_wr_req,
  input  logic             sdram_wr_ack,
  output logic [AW-1:0]    sdram_wr_addr,
  output logic [DW-1:0]    sdram_data_in,
  output logic             sdram_rd_req,
  input  logic             sdram_rd_ack,
  output logic [AW-1:0]    sdram_rd_addr,
  input  logic [DW-1:0]    sdram_data_out
);

  logic             w_wr_aclr_n, w_rd_aclr_n;
  logic [CNT_W-1:0] w_wr_used, w_rd_used, w_wr_fifo_wused_unused;
  logic             r_wr_ack_d, r_rd_ack_d, r_wr_req, r_rd_req;
  logic [AW-1:0]    r_wr_addr, r_rd_addr;
  req_e             w_req_nxt;

  assign w_wr_aclr_n = rst_n & ~wr_rst;
  assign w_rd_aclr_n = rst_n & ~rd_rst;

  async_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .i_aclr_n (w_wr_aclr_n),
    .i_wclk   (clk_50m),
    .i_wrreq  (wr_fifo_wr_req),
    .i_wdata  (wr_fifo_wr_data),
    .o_wusedw (w_wr_fifo_wused_unused),
    .i_rclk   (clk_100m),
    .i_rdreq  (sdram_wr_ack),
    .o_q      (sdram_data_in),
    .o_rusedw (w_wr_used)
  );

  async_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
    .i_aclr_n (w_rd_aclr_n),
    .i_wclk   (clk_100m),
    .i_wrreq  (sdram_rd_ack),
    .i_wdata  (sdram_data_out),
    .o_wusedw (w_rd_used),
    .i_rclk   (clk_50m),
    .i_rdreq  (rd_fifo_rd_req),
    .o_q      (rd_fifo_rd_data),
    .o_rusedw (rd_fifo_num)
  );

  // Advance by one burst, or wrap to the region start once the next burst
  // would no longer fit below the end address.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] cur, b, e,
                                              input logic [CNT_W-1:0] len);
    logic [AW-1:0] l;
    l = AW'(len);
    return (cur < (e - l)) ? (cur + l) : b;
  endfunction

  always_comb begin
    w_req_nxt = REQ_IDLE;
    if (init_end && !sdram_wr_ack && !sdram_rd_ack) begin
      if (w_wr_used >= wr_burst_len)                   w_req_nxt = REQ_WR;
      else if (read_valid && (w_rd_used < rd_burst_len)) w_req_nxt = REQ_RD;
    end
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_req <= 1'b0;
      r_rd_req <= 1'b0;
    end else begin
      r_wr_req <= (w_req_nxt == REQ_WR);
      r_rd_req <= (w_req_nxt == REQ_RD);
    end
  end

  always_ff @(posedge clk_100m or negedge w_wr_aclr_n) begin
    if (!w_wr_aclr_n) begin
      r_wr_ack_d <= 1'b0;
      r_wr_addr  <= sdram_wr_b_addr;
    end else begin
      r_wr_ack_d <= sdram_wr_ack;
      if (r_wr_ack_d && !sdram_wr_ack)
        r_wr_addr <= next_addr(r_wr_addr, sdram_wr_b_addr, sdram_wr_e_addr, wr_burst_len);
    end
  end

  always_ff @(posedge clk_100m or negedge w_rd_aclr_n) begin
    if (!w_rd_aclr_n) begin
      r_rd_ack_d <= 1'b0;
      r_rd_addr  <= sdram_rd_b_addr;
    end else begin
      r_rd_ack_d <= sdram_rd_ack;
      if (r_rd_ack_d && !sdram_rd_ack)
        r_rd_addr <= next_addr(r_rd_addr, sdram_rd_b_addr, sdram_rd_e_addr, rd_burst_len);
    end
  end

  assign sdram_wr_req  = r_wr_req;
  assign sdram_rd_req  = r_rd_req;
  assign sdram_wr_addr = r_wr_addr;
  assign sdram_rd_addr = r_rd_addr;

endmodule

// File: tb/tb_sdram_fifo_ctrl.sv
// Directed bench for sdram_fifo_ctrl: address-update vector table plus
// hand-written write/read burst, priority and reset sequences.
module tb_sdram_fifo_ctrl;

  logic        clk_50m, clk_100m, rst_n;
  logic        wr_fifo_wr_req, wr_rst, rd_fifo_rd_req, rd_rst, read_valid, init_end;
  logic [15:0] wr_fifo_wr_data, rd_fifo_rd_data, sdram_data_in, sdram_data_out;
  logic [23:0] sdram_wr_b_addr, sdram_wr_e_addr, sdram_rd_b_addr, sdram_rd_e_addr;
  logic [23:0] sdram_wr_addr, sdram_rd_addr;
  logic [9:0]  wr_burst_len, rd_burst_len, rd_fifo_num;
  logic        sdram_wr_req, sdram_wr_ack, sdram_rd_req, sdram_rd_ack;

  int n_cmp, n_bad;
  int wr_rises;
  bit wr_req_q;

  sdram_fifo_ctrl dut (
    .clk_50m(clk_50m), .clk_100m(clk_100m), .rst_n(rst_n),
    .wr_fifo_wr_req(wr_fifo_wr_req), .wr_fifo_wr_data(wr_fifo_wr_data),
    .sdram_wr_b_addr(sdram_wr_b_addr), .sdram_wr_e_addr(sdram_wr_e_addr),
    .wr_burst_len(wr_burst_len), .wr_rst(wr_rst),
    .rd_fifo_rd_req(rd_fifo_rd_req),
    .sdram_rd_b_addr(sdram_rd_b_addr), .sdram_rd_e_addr(sdram_rd_e_addr),
    .rd_burst_len(rd_burst_len), .rd_rst(rd_rst), .read_valid(read_valid),
    .rd_fifo_rd_data(rd_fifo_rd_data), .rd_fifo_num(rd_fifo_num),
    .init_end(init_end),
    .sdram_wr_req(sdram_wr_req), .sdram_wr_ack(sdram_wr_ack),
    .sdram_wr_addr(sdram_wr_addr), .sdram_data_in(sdram_data_in),
    .sdram_rd_req(sdram_rd_req), .sdram_rd_ack(sdram_rd_ack),
    .sdram_rd_addr(sdram_rd_addr), .sdram_data_out(sdram_data_out)
  );

  initial begin
    clk_50m = 1'b0;
    forever #10 clk_50m = ~clk_50m;
  end

  initial begin
    clk_100m = 1'b0;
    #2;
    forever #5 clk_100m = ~clk_100m;
  end

  always @(posedge clk_100m) begin
    wr_req_q <= sdram_wr_req;
    if (sdram_wr_req && !wr_req_q) wr_rises <= wr_rises + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          rst;
    bit          ack;
    logic [23:0] b;
    logic [23:0] e;
    logic [9:0]  len;
    logic [23:0] exp;
  } avec_t;

  avec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] v);
    @(negedge clk_50m);
    wr_fifo_wr_req  = 1'b1;
    wr_fifo_wr_data = v;
    @(negedge clk_50m);
    wr_fifo_wr_req  = 1'b0;
    repeat (6) @(negedge clk_50m);
  endtask

  task automatic pulse_rst(input bit w, input bit r);
    @(negedge clk_100m);
    #1;
    wr_rst = w;
    rd_rst = r;
    #2;
    wr_rst = 1'b0;
    rd_rst = 1'b0;
  endtask

  task automatic wait_req(input bit rd, input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_100m);
      if (rd ? sdram_rd_req : sdram_wr_req) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, {31'd0, ok}, 32'd1);
  endtask

  task automatic set_region(input logic [23:0] b, input logic [23:0] e, input logic [9:0] len);
    sdram_wr_b_addr = b; sdram_wr_e_addr = e; wr_burst_len = len;
    sdram_rd_b_addr = b; sdram_rd_e_addr = e; rd_burst_len = len;
  endtask

  initial begin
    int base;
    logic [23:0] prev;
    n_cmp = 0; n_bad = 0; wr_rises = 0;
    rst_n = 1'b0; wr_rst = 1'b0; rd_rst = 1'b0;
    wr_fifo_wr_req = 1'b0; wr_fifo_wr_data = '0; rd_fifo_rd_req = 1'b0;
    read_valid = 1'b0; init_end = 1'b0;
    sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0; sdram_data_out = '0;
    sdram_wr_b_addr = 24'h000123; sdram_wr_e_addr = 24'h000400; wr_burst_len = 10'd10;
    sdram_rd_b_addr = 24'h000456; sdram_rd_e_addr = 24'h000800; rd_burst_len = 10'd10;

    tbl[0]  = '{1'b1, 1'b0, 24'h000100, 24'h000140, 10'h010, 24'h000100};
    tbl[1]  = '{1'b0, 1'b1, 24'h000100, 24'h000140, 10'h010, 24'h000110};
    tbl[2]  = '{1'b0, 1'b1, 24'h000100, 24'h000140, 10'h010, 24'h000120};
    tbl[3]  = '{1'b0, 1'b1, 24'h000100, 24'h000140, 10'h010, 24'h000130};
    tbl[4]  = '{1'b0, 1'b1, 24'h000100, 24'h000140, 10'h010, 24'h000100};
    tbl[5]  = '{1'b1, 1'b0, 24'h000000, 24'h00000A, 10'h00A, 24'h000000};
    tbl[6]  = '{1'b0, 1'b1, 24'h000000, 24'h00000A, 10'h00A, 24'h000000};
    tbl[7]  = '{1'b1, 1'b0, 24'h000020, 24'h001000, 10'h100, 24'h000020};
    tbl[8]  = '{1'b0, 1'b1, 24'h000020, 24'h001000, 10'h100, 24'h000120};
    tbl[9]  = '{1'b0, 1'b1, 24'h000020, 24'h001000, 10'h100, 24'h000220};
    tbl[10] = '{1'b1, 1'b0, 24'h000000, 24'h000020, 10'h010, 24'h000000};
    tbl[11] = '{1'b0, 1'b1, 24'h000000, 24'h000020, 10'h010, 24'h000010};
    tbl[12] = '{1'b0, 1'b1, 24'h000000, 24'h000020, 10'h010, 24'h000000};
    tbl[13] = '{1'b1, 1'b0, 24'hFFFF00, 24'hFFFFFF, 10'h080, 24'hFFFF00};
    tbl[14] = '{1'b0, 1'b1, 24'hFFFF00, 24'hFFFFFF, 10'h080, 24'hFFFF80};
    tbl[15] = '{1'b0, 1'b1, 24'hFFFF00, 24'hFFFFFF, 10'h080, 24'hFFFF00};
    tbl[16] = '{1'b1, 1'b0, 24'h000005, 24'h000003, 10'h008, 24'h000005};
    tbl[17] = '{1'b0, 1'b1, 24'h000005, 24'h000003, 10'h008, 24'h00000D};

    // Reset state
    #30;
    chk("rst_wr_req",  {31'd0, sdram_wr_req}, 32'd0);
    chk("rst_rd_req",  {31'd0, sdram_rd_req}, 32'd0);
    chk("rst_wr_addr", sdram_wr_addr, 32'h000123);
    chk("rst_rd_addr", sdram_rd_addr, 32'h000456);
    chk("rst_rd_num",  rd_fifo_num, 32'd0);
    chk("rst_rd_data", rd_fifo_rd_data, 32'd0);
    chk("rst_data_in", sdram_data_in, 32'd0);
    #23;
    rst_n = 1'b1;
    repeat (3) @(negedge clk_100m);

    // Address-update vectors, init_end low so no requests interfere
    prev = '0;
    foreach (tbl[k]) begin
      set_region(tbl[k].b, tbl[k].e, tbl[k].len);
      if (tbl[k].rst) begin
        pulse_rst(1'b1, 1'b1);
        #1;
      end
      if (tbl[k].ack) begin
        @(negedge clk_100m);
        sdram_wr_ack = 1'b1; sdram_rd_ack = 1'b1;
        repeat (3) @(negedge clk_100m);
        chk($sformatf("wr_addr_hold[%0d]", k), sdram_wr_addr, prev);
        chk($sformatf("rd_addr_hold[%0d]", k), sdram_rd_addr, prev);
        sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0;
        @(negedge clk_100m);
      end
      chk($sformatf("wr_addr[%0d]", k), sdram_wr_addr, tbl[k].exp);
      chk($sformatf("rd_addr[%0d]", k), sdram_rd_addr, tbl[k].exp);
      prev = tbl[k].exp;
    end

    // init gating and the first write burst
    set_region(24'h000000, 24'h00000A, 10'd10);
    pulse_rst(1'b1, 1'b1);
    base = wr_rises;
    for (int v = 1; v <= 10; v++) push(16'(v));
    repeat (10) @(negedge clk_100m);
    chk("no_wr_req_pre_init", wr_rises - base, 0);
    chk("wr_req_low_pre_init", {31'd0, sdram_wr_req}, 32'd0);
    init_end = 1'b1;
    @(negedge clk_100m);
    chk("wr_req_after_init", {31'd0, sdram_wr_req}, 32'd1);
    chk("wr_addr_burst", sdram_wr_addr, 32'd0);
    sdram_wr_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_100m);
      if (i == 0) chk("wr_req_drop_on_ack", {31'd0, sdram_wr_req}, 32'd0);
      chk($sformatf("data_in[%0d]", i), sdram_data_in, 32'(i + 1));
    end
    sdram_wr_ack = 1'b0;
    @(negedge clk_100m);
    chk("wr_addr_wrap", sdram_wr_addr, 32'd0);
    repeat (20) @(negedge clk_100m);
    chk("wr_req_count", wr_rises - base, 1);

    // read burst into the read FIFO, then drain at 50 MHz
    read_valid = 1'b1;
    wait_req(1'b1, 5, "rd_req_rise");
    chk("rd_addr_burst", sdram_rd_addr, 32'd0);
    sdram_rd_ack = 1'b1;
    sdram_data_out = 16'd1;
    for (int i = 1; i < 10; i++) begin
      @(negedge clk_100m);
      sdram_data_out = 16'(i + 1);
      if (i == 1) chk("rd_req_drop_on_ack", {31'd0, sdram_rd_req}, 32'd0);
    end
    @(negedge clk_100m);
    sdram_rd_ack = 1'b0;
    read_valid = 1'b0;
    @(negedge clk_100m);
    chk("rd_addr_wrap", sdram_rd_addr, 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_50m);
      if (rd_fifo_num == 10'd10) break;
    end
    chk("rd_fifo_num_full", rd_fifo_num, 32'd10);
    @(negedge clk_50m);
    rd_fifo_rd_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_50m);
      chk($sformatf("rd_data[%0d]", i), rd_fifo_rd_data, 32'(i + 1));
    end
    rd_fifo_rd_req = 1'b0;
    @(negedge clk_50m);
    rd_fifo_rd_req = 1'b1;
    @(negedge clk_50m);
    rd_fifo_rd_req = 1'b0;
    chk("rd_data_empty_hold", rd_fifo_rd_data, 32'd10);
    repeat (2) @(negedge clk_50m);
    chk("rd_fifo_num_empty", rd_fifo_num, 32'd0);

    // write has priority over read when both hold
    init_end = 1'b0;
    pulse_rst(1'b0, 1'b1);
    read_valid = 1'b1;
    for (int v = 0; v < 10; v++) push(16'(16'h100 + v));
    repeat (10) @(negedge clk_100m);
    init_end = 1'b1;
    @(negedge clk_100m);
    chk("prio_wr_req", {31'd0, sdram_wr_req}, 32'd1);
    chk("prio_rd_req", {31'd0, sdram_rd_req}, 32'd0);
    sdram_wr_ack = 1'b1;
    repeat (10) @(negedge clk_100m);
    sdram_wr_ack = 1'b0;
    wait_req(1'b1, 5, "rd_req_after_wr");
    chk("no_wr_req_after_drain", {31'd0, sdram_wr_req}, 32'd0);
    read_valid = 1'b0;
    repeat (2) @(negedge clk_100m);
    chk("rd_req_off", {31'd0, sdram_rd_req}, 32'd0);

    // wr_rst mid-stream discards queued words and reloads the begin address
    sdram_wr_b_addr = 24'h000040;
    for (int v = 0; v < 8; v++) push(16'(16'h200 + v));
    chk("wr_addr_pre_rst", sdram_wr_addr, 32'd0);
    base = wr_rises;
    pulse_rst(1'b1, 1'b0);
    #1;
    chk("wr_addr_after_rst", sdram_wr_addr, 32'h000040);
    for (int v = 0; v < 5; v++) push(16'(16'h300 + v));
    repeat (20) @(negedge clk_100m);
    chk("no_wr_req_after_rst", wr_rises - base, 0);
    chk("wr_req_low_after_rst", {31'd0, sdram_wr_req}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
